// File: rtl/ef_adc_pp_pkg.sv
// Shared defaults and types for the ADC post-processing averager.
package ef_adc_pp_pkg;

  localparam int unsigned ADC_DW      = 10;
  localparam int unsigned ADC_CHW     = 3;
  localparam int unsigned ADC_MAXLOG2 = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/ef_adc_win_cmp.sv
// Window comparator: flags a result outside [lo, hi] as a one-cycle registered pulse.
module ef_adc_win_cmp #(
  parameter int unsigned DW = ef_adc_pp_pkg::ADC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] res,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] hi,
  output logic          win_irq
);

  logic out_c;

  // An inverted window (lo > hi) makes every value fall outside.
  assign out_c = (res < lo) || (res > hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_irq <= 1'b0;
    end else begin
      win_irq <= load && out_c;
    end
  end

endmodule

// File: rtl/ef_adc_avg_win.sv
// Per-channel power-of-two sample averager with a one-deep result register and window alarm.
module ef_adc_avg_win #(
  parameter int unsigned DW      = ef_adc_pp_pkg::ADC_DW,
  parameter int unsigned CHW     = ef_adc_pp_pkg::ADC_CHW,
  parameter int unsigned MAXLOG2 = ef_adc_pp_pkg::ADC_MAXLOG2
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           en,
  input  logic           clr,
  input  logic [2:0]     avg_log2,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [CHW-1:0] s_ch,
  input  logic [DW-1:0]  s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [CHW-1:0] m_ch,
  output logic [DW-1:0]  m_data,
  input  logic [DW-1:0]  win_lo,
  input  logic [DW-1:0]  win_hi,
  output logic           win_irq
);
  import ef_adc_pp_pkg::*;

  localparam int unsigned NCH = 2 ** CHW;
  localparam int unsigned AW  = DW + MAXLOG2;
  localparam int unsigned CW  = MAXLOG2 + 1;

  logic [AW-1:0] acc [NCH];
  logic [CW-1:0] cnt [NCH];

  out_state_e    state;
  logic          run;
  logic          accept;
  logic          complete;
  logic [2:0]    eff_log2;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] target;
  logic [DW-1:0] res_c;

  // run holds s_ready low through reset and the first cycle after release.
  assign m_valid  = (state == FULL);
  assign s_ready  = run && en && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;

  assign eff_log2 = (avg_log2 > 3'(MAXLOG2)) ? 3'(MAXLOG2) : avg_log2;
  assign sum      = acc[s_ch] + AW'(s_data);
  assign cnt_nxt  = cnt[s_ch] + CW'(1);
  assign target   = CW'(1) << eff_log2;
  assign res_c    = DW'(sum >> eff_log2);

  // >= rather than == so a shrinking avg_log2 still completes a channel.
  assign complete = accept && !clr && (cnt_nxt >= target);

  // Accumulator bank.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      run <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (clr) begin
        for (int i = 0; i < int'(NCH); i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end else if (accept) begin
        if (complete) begin
          acc[s_ch] <= '0;
          cnt[s_ch] <= '0;
        end else begin
          acc[s_ch] <= sum;
          cnt[s_ch] <= cnt_nxt;
        end
      end
    end
  end

  // Output register FSM; a completion while FULL is only possible with m_ready high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= EMPTY;
      m_ch   <= '0;
      m_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            state  <= FULL;
            m_ch   <= s_ch;
            m_data <= res_c;
          end
        end
        FULL: begin
          if (complete) begin
            m_ch   <= s_ch;
            m_data <= res_c;
          end else if (m_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  ef_adc_win_cmp #(
    .DW(DW)
  ) u_win_cmp (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .load    (complete),
    .res     (res_c),
    .lo      (win_lo),
    .hi      (win_hi),
    .win_irq (win_irq)
  );

endmodule
